// File: rtl/otp_cmd_seq_if.sv
// rtl/otp_cmd_seq_if.sv - request/response and OTP macro command bundle for otp_cmd_seq
interface otp_cmd_seq_if #(
    parameter int Width     = 16,
    parameter int SizeWidth = 2,
    parameter int AddrWidth = 10,
    parameter int CmdWidth  = 3,
    parameter int ErrWidth  = 3
);
    localparam int IfWidth = (2**SizeWidth) * Width;

    // controller side request
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_write_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [SizeWidth-1:0] req_size_i;
    logic [IfWidth-1:0]   req_wdata_i;

    // controller side response
    logic                 rsp_valid_o;
    logic [IfWidth-1:0]   rsp_rdata_o;
    logic [ErrWidth-1:0]  rsp_err_o;
    logic                 rsp_timeout_o;
    logic                 init_done_o;
    logic                 fatal_o;

    // macro command port
    logic                 otp_ready_i;
    logic                 otp_valid_o;
    logic [CmdWidth-1:0]  otp_cmd_o;
    logic [SizeWidth-1:0] otp_size_o;
    logic [AddrWidth-1:0] otp_addr_o;
    logic [IfWidth-1:0]   otp_wdata_o;

    // macro response port
    logic                 otp_valid_i;
    logic [IfWidth-1:0]   otp_rdata_i;
    logic [ErrWidth-1:0]  otp_err_i;

    // sequencer view
    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
        input  otp_ready_i, otp_valid_i, otp_rdata_i, otp_err_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output init_done_o, fatal_o,
        output otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o, otp_wdata_o
    );

    // controller plus macro view, used by whoever drives the sequencer
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
        output otp_ready_i, otp_valid_i, otp_rdata_i, otp_err_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  init_done_o, fatal_o,
        input  otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o, otp_wdata_o
    );
endinterface

// File: rtl/otp_cmd_seq.sv
// rtl/otp_cmd_seq.sv - OTP macro command sequencer with init, range check and timeout
module otp_cmd_seq #(
    parameter int Width         = 16,
    parameter int SizeWidth     = 2,
    parameter int AddrWidth     = 10,
    parameter int CmdWidth      = 3,
    parameter int ErrWidth      = 3,
    parameter int TimeoutCycles = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    otp_cmd_seq_if.slave   bus
);
    localparam int IfWidth  = (2**SizeWidth) * Width;
    // one spare bit so the counter can never wrap while the budget is being checked
    localparam int CntWidth = $clog2(TimeoutCycles) + 1;
    // the decision is taken one cycle before the registered response becomes visible
    localparam logic [CntWidth-1:0] TmoLast = CntWidth'(TimeoutCycles - 2);

    // macro command encodings
    localparam logic [CmdWidth-1:0] OtpRead  = CmdWidth'(0);
    localparam logic [CmdWidth-1:0] OtpWrite = CmdWidth'(1);
    localparam logic [CmdWidth-1:0] OtpInit  = CmdWidth'(7);

    // error codes produced locally
    localparam logic [ErrWidth-1:0] NoErr        = ErrWidth'(0);
    localparam logic [ErrWidth-1:0] OtpCmdInvErr = ErrWidth'(1);

    typedef enum logic [2:0] {
        ResetSt    = 3'd0,
        InitCmdSt  = 3'd1,
        InitWaitSt = 3'd2,
        IdleSt     = 3'd3,
        CmdSt      = 3'd4,
        WaitSt     = 3'd5,
        ErrorSt    = 3'd6
    } state_e;

    state_e                r_state;
    state_e                w_next_state;
    logic [CntWidth-1:0]   r_tmo_cnt;

    logic                  r_write;
    logic [AddrWidth-1:0]  r_addr;
    logic [SizeWidth-1:0]  r_size;
    logic [IfWidth-1:0]    r_wdata;
    logic [CmdWidth-1:0]   r_cmd;

    logic                  r_rsp_valid;
    logic [IfWidth-1:0]    r_rsp_rdata;
    logic [ErrWidth-1:0]   r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_init_done;
    logic                  r_rej;

    logic                  w_req_ready;
    logic                  w_handshake;
    logic [AddrWidth:0]    w_end_addr;
    logic                  w_range_bad;
    logic                  w_tmo_hit;
    logic [IfWidth-1:0]    w_rd_masked;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_set_init;
    logic                  w_issue_init;
    logic                  w_rsp_load;
    logic                  w_rsp_tmo;
    logic [ErrWidth-1:0]   w_rsp_err;
    logic [IfWidth-1:0]    w_rsp_data;

    // ready is a pure state decode; the cycle after a range reject is blocked so the
    // reject response is not overlapped by a new acceptance
    assign w_req_ready = (r_state == IdleSt) && !r_rej;
    assign w_handshake = bus.req_valid_i && w_req_ready;
    assign w_end_addr  = {1'b0, bus.req_addr_i}
                       + {{(AddrWidth + 1 - SizeWidth){1'b0}}, bus.req_size_i};
    assign w_range_bad = w_end_addr[AddrWidth];
    assign w_tmo_hit   = (r_tmo_cnt >= TmoLast);

    // read data keeps only the requested words; writes always return zero
    always_comb begin
        w_rd_masked = '0;
        if (!r_write) begin
            for (int k = 0; k < 2**SizeWidth; k++) begin
                if (SizeWidth'(k) <= r_size) begin
                    w_rd_masked[k*Width +: Width] = bus.otp_rdata_i[k*Width +: Width];
                end
            end
        end
    end

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ResetSt;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state decode and the strobes that steer the datapath registers
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_cnt_en     = 1'b0;
        w_set_init   = 1'b0;
        w_issue_init = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_tmo    = 1'b0;
        w_rsp_err    = NoErr;
        w_rsp_data   = '0;
        unique case (r_state)
            ResetSt: begin
                w_next_state = InitCmdSt;
                w_issue_init = 1'b1;
            end
            InitCmdSt: begin
                w_cnt_en = 1'b1;
                if (bus.otp_ready_i) begin
                    w_next_state = InitWaitSt;
                end else if (w_tmo_hit) begin
                    w_next_state = ErrorSt;
                end
            end
            InitWaitSt: begin
                w_cnt_en = 1'b1;
                if (bus.otp_valid_i) begin
                    if (bus.otp_err_i == NoErr) begin
                        w_next_state = IdleSt;
                        w_set_init   = 1'b1;
                    end else begin
                        w_next_state = ErrorSt;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = ErrorSt;
                end
            end
            IdleSt: begin
                if (w_handshake) begin
                    if (w_range_bad) begin
                        w_reject   = 1'b1;
                        w_rsp_load = 1'b1;
                        w_rsp_err  = OtpCmdInvErr;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = CmdSt;
                    end
                end
            end
            CmdSt: begin
                w_cnt_en = 1'b1;
                if (bus.otp_ready_i) begin
                    w_next_state = WaitSt;
                end else if (w_tmo_hit) begin
                    w_next_state = ErrorSt;
                    w_rsp_load   = 1'b1;
                    w_rsp_tmo    = 1'b1;
                end
            end
            WaitSt: begin
                w_cnt_en = 1'b1;
                // a response in the final budget cycle still wins over the timeout
                if (bus.otp_valid_i) begin
                    w_next_state = IdleSt;
                    w_rsp_load   = 1'b1;
                    w_rsp_err    = bus.otp_err_i;
                    w_rsp_data   = w_rd_masked;
                end else if (w_tmo_hit) begin
                    w_next_state = ErrorSt;
                    w_rsp_load   = 1'b1;
                    w_rsp_tmo    = 1'b1;
                end
            end
            ErrorSt: begin
                w_next_state = ErrorSt;
            end
            default: begin
                w_next_state = ErrorSt;
            end
        endcase
    end

    // the counter restarts whenever a state with its own wait budget is freshly entered
    assign w_cnt_clr = (w_next_state != r_state) &&
                       ((w_next_state == InitCmdSt) || (w_next_state == CmdSt) ||
                        (w_next_state == WaitSt));

    // timeout counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_tmo_cnt <= '0;
        end else if (w_cnt_en) begin
            r_tmo_cnt <= r_tmo_cnt + CntWidth'(1);
        end
    end

    // request capture and registered macro command payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_cmd   <= '0;
        end else if (w_issue_init) begin
            r_cmd <= OtpInit;
        end else if (w_accept) begin
            r_write <= bus.req_write_i;
            r_addr  <= bus.req_addr_i;
            r_size  <= bus.req_size_i;
            r_wdata <= bus.req_wdata_i;
            r_cmd   <= bus.req_write_i ? OtpWrite : OtpRead;
        end
    end

    // response registers hold their contents until the next strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_load;
            if (w_rsp_load) begin
                r_rsp_rdata   <= w_rsp_data;
                r_rsp_err     <= w_rsp_err;
                r_rsp_timeout <= w_rsp_tmo;
            end
        end
    end

    // sticky init flag and the one-cycle ready block after a range reject
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_init_done <= 1'b0;
            r_rej       <= 1'b0;
        end else begin
            r_rej <= w_reject;
            if (w_set_init) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o   = w_req_ready;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;
    assign bus.init_done_o   = r_init_done;
    assign bus.fatal_o       = (r_state == ErrorSt);
    assign bus.otp_valid_o   = (r_state == InitCmdSt) || (r_state == CmdSt);
    assign bus.otp_cmd_o     = r_cmd;
    assign bus.otp_size_o    = r_size;
    assign bus.otp_addr_o    = r_addr;
    assign bus.otp_wdata_o   = r_wdata;
endmodule

// File: tb/tb_otp_cmd_seq.sv
// tb/tb_otp_cmd_seq.sv - directed self-checking bench for otp_cmd_seq
module tb_otp_cmd_seq;
    localparam logic [2:0] CMD_READ   = 3'd0;
    localparam logic [2:0] CMD_WRITE  = 3'd1;
    localparam logic [2:0] CMD_INIT   = 3'd7;
    localparam logic [2:0] ERR_NO     = 3'd0;
    localparam logic [2:0] ERR_CMDINV = 3'd1;
    localparam logic [2:0] ERR_RDCORR = 3'd3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_wait;

    otp_cmd_seq_if #(.Width(16), .SizeWidth(2), .AddrWidth(10), .CmdWidth(3), .ErrWidth(3)) bus ();

    otp_cmd_seq #(
        .Width(16), .SizeWidth(2), .AddrWidth(10), .CmdWidth(3), .ErrWidth(3),
        .TimeoutCycles(1024)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [9:0] addr, input logic [1:0] size,
                           input logic [63:0] wdata);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = addr;
        bus.req_size_i  = size;
        bus.req_wdata_i = wdata;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_size_i  = '0;
        bus.req_wdata_i = '0;
        bus.otp_ready_i = 1'b1;
        bus.otp_valid_i = 1'b0;
        bus.otp_rdata_i = '0;
        bus.otp_err_i   = '0;
        tick();
        tick();

        // reset state
        chk("rst_otp_valid", 64'(bus.otp_valid_o), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_init_done", 64'(bus.init_done_o), 64'd0);
        chk("rst_fatal", 64'(bus.fatal_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_otp_cmd", 64'(bus.otp_cmd_o), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 64'd0);

        // init sequence: one command, response one cycle later
        rst = 1'b0;
        tick();
        chk("init_valid", 64'(bus.otp_valid_o), 64'd1);
        chk("init_cmd", 64'(bus.otp_cmd_o), 64'(CMD_INIT));
        tick();
        chk("init_single", 64'(bus.otp_valid_o), 64'd0);
        chk("init_not_done", 64'(bus.init_done_o), 64'd0);
        bus.otp_valid_i = 1'b1;
        bus.otp_err_i   = ERR_NO;
        tick();
        bus.otp_valid_i = 1'b0;
        chk("init_done", 64'(bus.init_done_o), 64'd1);
        chk("idle_ready", 64'(bus.req_ready_o), 64'd1);
        chk("idle_no_cmd", 64'(bus.otp_valid_o), 64'd0);

        // read addr 0x010 size 3, corrected-error pass-through, minimum latency
        request(1'b0, 10'h010, 2'd3, 64'd0);
        chk("rd_valid", 64'(bus.otp_valid_o), 64'd1);
        chk("rd_cmd", 64'(bus.otp_cmd_o), 64'(CMD_READ));
        chk("rd_addr", 64'(bus.otp_addr_o), 64'h010);
        chk("rd_size", 64'(bus.otp_size_o), 64'd3);
        chk("rd_busy", 64'(bus.req_ready_o), 64'd0);
        tick();
        chk("rd_wait_nocmd", 64'(bus.otp_valid_o), 64'd0);
        chk("rd_wait_norsp", 64'(bus.rsp_valid_o), 64'd0);
        bus.otp_valid_i = 1'b1;
        bus.otp_rdata_i = 64'h0123_4567_89AB_CDEF;
        bus.otp_err_i   = ERR_RDCORR;
        tick();
        bus.otp_valid_i = 1'b0;
        bus.otp_err_i   = ERR_NO;
        chk("rd_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("rd_rsp_data", bus.rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
        chk("rd_rsp_err", 64'(bus.rsp_err_o), 64'(ERR_RDCORR));
        chk("rd_rsp_tmo", 64'(bus.rsp_timeout_o), 64'd0);
        tick();
        chk("rd_rsp_pulse", 64'(bus.rsp_valid_o), 64'd0);
        chk("rd_rsp_hold", bus.rsp_rdata_o, 64'h0123_4567_89AB_CDEF);

        // read size 1 with all-ones macro data: upper words masked
        request(1'b0, 10'h020, 2'd1, 64'd0);
        tick();
        bus.otp_valid_i = 1'b1;
        bus.otp_rdata_i = '1;
        tick();
        bus.otp_valid_i = 1'b0;
        chk("mask_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("mask_rsp_data", bus.rsp_rdata_o, 64'h0000_0000_FFFF_FFFF);
        chk("mask_rsp_err", 64'(bus.rsp_err_o), 64'(ERR_NO));
        tick();

        // range reject: 0x3FE + 2 overflows the address space
        request(1'b1, 10'h3FE, 2'd2, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("rej_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("rej_rsp_err", 64'(bus.rsp_err_o), 64'(ERR_CMDINV));
        chk("rej_rsp_data", bus.rsp_rdata_o, 64'd0);
        chk("rej_no_cmd", 64'(bus.otp_valid_o), 64'd0);
        chk("rej_ready_low", 64'(bus.req_ready_o), 64'd0);
        tick();
        chk("rej_rsp_pulse", 64'(bus.rsp_valid_o), 64'd0);
        chk("rej_ready_back", 64'(bus.req_ready_o), 64'd1);
        chk("rej_still_no_cmd", 64'(bus.otp_valid_o), 64'd0);

        // 0x3FD + 2 is the last legal span; macro stalls one cycle
        bus.otp_ready_i = 1'b0;
        request(1'b1, 10'h3FD, 2'd2, 64'h1111_2222_3333_4444);
        chk("wr_valid", 64'(bus.otp_valid_o), 64'd1);
        chk("wr_cmd", 64'(bus.otp_cmd_o), 64'(CMD_WRITE));
        chk("wr_addr", 64'(bus.otp_addr_o), 64'h3FD);
        chk("wr_size", 64'(bus.otp_size_o), 64'd2);
        chk("wr_wdata", bus.otp_wdata_o, 64'h1111_2222_3333_4444);
        tick();
        chk("wr_valid_held", 64'(bus.otp_valid_o), 64'd1);
        chk("wr_addr_held", 64'(bus.otp_addr_o), 64'h3FD);
        bus.otp_ready_i = 1'b1;
        tick();
        chk("wr_cmd_done", 64'(bus.otp_valid_o), 64'd0);
        bus.otp_valid_i = 1'b1;
        bus.otp_rdata_i = '1;
        tick();
        bus.otp_valid_i = 1'b0;
        chk("wr_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("wr_rsp_zero", bus.rsp_rdata_o, 64'd0);
        tick();

        // timeout while the macro never becomes ready
        bus.otp_ready_i = 1'b0;
        request(1'b0, 10'h001, 2'd0, 64'd0);
        chk("tmo_cmd_valid", 64'(bus.otp_valid_o), 64'd1);
        n_wait = 0;
        while (!bus.rsp_valid_o && n_wait < 2000) begin
            tick();
            n_wait++;
        end
        chk("tmo_latency", 64'(n_wait), 64'd1023);
        chk("tmo_flag", 64'(bus.rsp_timeout_o), 64'd1);
        chk("tmo_err", 64'(bus.rsp_err_o), 64'(ERR_NO));
        chk("tmo_fatal", 64'(bus.fatal_o), 64'd1);
        chk("tmo_ready", 64'(bus.req_ready_o), 64'd0);
        bus.req_valid_i = 1'b1;
        bus.otp_ready_i = 1'b1;
        tick();
        tick();
        bus.req_valid_i = 1'b0;
        chk("err_fatal_sticky", 64'(bus.fatal_o), 64'd1);
        chk("err_no_cmd", 64'(bus.otp_valid_o), 64'd0);
        chk("err_rsp_pulse", 64'(bus.rsp_valid_o), 64'd0);

        // reset recovers and reissues init
        rst = 1'b1;
        tick();
        chk("rst2_fatal", 64'(bus.fatal_o), 64'd0);
        chk("rst2_init_done", 64'(bus.init_done_o), 64'd0);
        rst = 1'b0;
        tick();
        chk("reinit_valid", 64'(bus.otp_valid_o), 64'd1);
        chk("reinit_cmd", 64'(bus.otp_cmd_o), 64'(CMD_INIT));

        // init failure is fatal and later responses are ignored
        tick();
        bus.otp_valid_i = 1'b1;
        bus.otp_err_i   = ERR_CMDINV;
        tick();
        chk("initfail_fatal", 64'(bus.fatal_o), 64'd1);
        chk("initfail_done", 64'(bus.init_done_o), 64'd0);
        bus.otp_err_i = ERR_NO;
        tick();
        tick();
        bus.otp_valid_i = 1'b0;
        chk("initfail_ignore", 64'(bus.init_done_o), 64'd0);
        chk("initfail_sticky", 64'(bus.fatal_o), 64'd1);
        chk("initfail_ready", 64'(bus.req_ready_o), 64'd0);
        chk("initfail_no_rsp", 64'(bus.rsp_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/otp_cmd_seq.md
# otp_cmd_seq

Command sequencer directly upstream of the OTP macro wrapper (`prim_otp`). After reset it issues the mandatory init command to the macro. It then accepts single read or write requests from the controller's direct-access logic and drives the macro's ready/valid command port. It returns the macro response, with a per-request timeout, and latches a terminal fatal state when the macro misbehaves.

## Interface
Parameters:
- Width, 16, native OTP word width.
- SizeWidth, 2, width of the size field; up to 2**SizeWidth native words per request.
- AddrWidth, 10, native-word address width.
- CmdWidth, `otp_ctrl_pkg::OtpCmdWidth`, command field width.
- ErrWidth, `otp_ctrl_pkg::OtpErrWidth`, error code width.
- TimeoutCycles, 1024, wait budget per macro transaction; must be ≥ 2.
- Derived: IfWidth = 2**SizeWidth*Width.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  start native-word address.
- req_size_i  in  SizeWidth  number of words − 1.
- req_wdata_i  in  IfWidth  write data; word k at bits [k*Width +: Width].
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  IfWidth  read data; words above size are zero.
- rsp_err_o  out  ErrWidth  `otp_ctrl_pkg` error code.
- rsp_timeout_o  out  1  response ended by timeout.
- init_done_o  out  1  macro initialised; sticky.
- fatal_o  out  1  terminal error; sticky until reset.
- otp_ready_i  in  1  macro command ready.
- otp_valid_o  out  1  macro command valid.
- otp_cmd_o  out  CmdWidth  OtpRead / OtpWrite / OtpInit.
- otp_size_o  out  SizeWidth, otp_addr_o  out  AddrWidth, otp_wdata_o  out  IfWidth  command payload.
- otp_valid_i  in  1, otp_rdata_i  in  IfWidth, otp_err_i  in  ErrWidth  macro response.

## Operation
- FSM states: ResetSt, InitCmdSt, InitWaitSt, IdleSt, CmdSt, WaitSt, ErrorSt.
- ResetSt: entered on reset. Unconditionally moves to InitCmdSt on the first clock after rst_i deasserts.
- InitCmdSt: otp_valid_o=1, otp_cmd_o=OtpInit. On otp_ready_i, go to InitWaitSt.
- InitWaitSt: on otp_valid_i:
  - otp_err_i==NoErr → IdleSt and set init_done_o.
  - otherwise → ErrorSt.
- IdleSt: req_ready_o=1. On handshake, capture write, addr, size and wdata.
  - Range check in AddrWidth+1 bits: if addr+size > 2**AddrWidth−1, the macro is not accessed. Next cycle rsp_valid_o=1 with rsp_err_o=OtpCmdInvErr and rdata=0. Stay in IdleSt.
  - Otherwise go to CmdSt.
- CmdSt: otp_valid_o=1 with the captured payload; cmd is OtpWrite if write, else OtpRead. On otp_ready_i, go to WaitSt.
- WaitSt: on otp_valid_i, capture rdata (reads only, masked to size+1 words; writes return 0) and otp_err_i. Pulse rsp_valid_o and return to IdleSt.
  - A macro error code is passed through and is not fatal.
- Timeout counter:
  - Clears on entry to InitCmdSt, CmdSt and WaitSt, and counts every cycle in InitCmdSt, InitWaitSt, CmdSt and WaitSt.
  - Reaching TimeoutCycles−1 without the awaited ready/valid → ErrorSt.
  - If a request was in flight, also pulse rsp_valid_o with rsp_timeout_o=1 and rsp_err_o=NoErr.
- ErrorSt: terminal until reset. fatal_o=1, req_ready_o=0, otp_valid_o=0; otp_valid_i is ignored.
- An otp_valid_i arriving in any state other than InitWaitSt or WaitSt is ignored.
- Any unreachable state encoding → ErrorSt.

## Timing
- Reset values:
  - All outputs are 0, including payload, rsp_* and init_done_o.
  - State is ResetSt, timeout counter is 0.
- req_ready_o and otp_valid_o are decoded from the registered state only; no combinational path from inputs.
- otp_* payload is registered and stable while otp_valid_o=1. Once asserted, otp_valid_o stays high until otp_ready_i.
- Minimum request latency: accept at cycle N, otp_valid_o at N+1. With otp_ready_i=1 at N+1 and otp_valid_i at N+2, rsp_valid_o is at N+3.
- Range-reject latency: rsp_valid_o at N+1, and req_ready_o is low for that cycle.
- rsp_rdata_o, rsp_err_o and rsp_timeout_o hold their values until the next rsp_valid_o.
- Timeout fires exactly TimeoutCycles−1 cycles after state entry. If otp_valid_i arrives in that same cycle, the response wins and there is no timeout.
- Reset asserted mid-transaction aborts immediately, with no response. Init is reissued after deassert.

## Test plan
- Reset release with otp_ready_i=1 and otp_valid_i one cycle after the init command, otp_err_i=0 → exactly one OtpInit command; init_done_o=1; req_ready_o=1 afterwards.
- Read addr=0x010, size=3; macro returns rdata=0x0123_4567_89AB_CDEF, err=OtpReadCorrErr → otp_addr_o=0x010, otp_size_o=3, cmd=OtpRead; response carries the same data and err; latency 3 cycles.
- Read size=1 where the macro drives all-ones on otp_rdata_i → rsp_rdata_o=0x0000_0000_FFFF_FFFF.
- Write addr=0x3FE, size=2 → no otp_valid_o; rsp_err_o=OtpCmdInvErr one cycle after accept. Then write addr=0x3FD, size=2 → accepted and forwarded.
- Timeout: read accepted, otp_ready_i held low → rsp_valid_o with rsp_timeout_o=1 exactly 1023 cycles after CmdSt entry. fatal_o=1, req_ready_o=0 until reset; a reset then reissues init.
- Init failure: init response with err=OtpCmdInvErr → fatal_o=1, init_done_o=0; later otp_valid_i pulses are ignored.
